// File: rtl/capture_ctrl.sv
// Capture sequencer: paced sampling, pattern/edge trigger,
// ring-buffer write pointer and oldest-first readout.
module capture_ctrl #(
  parameter int AW    = 10,
  parameter int DIVW  = 16,
  parameter int POSTW = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arm,
  input  logic             abort,
  input  logic [DIVW-1:0]  div,
  input  logic [AW-1:0]    pre_min,
  input  logic [POSTW-1:0] post_len,
  input  logic [7:0]       trig_mask,
  input  logic [7:0]       trig_val,
  input  logic             trig_edge,
  input  logic [7:0]       din_sync,
  output logic             sample_en,
  output logic             wr_en,
  output logic [AW-1:0]    wptr,
  output logic [AW-1:0]    trig_ptr,
  output logic [2:0]       state,
  output logic             done,
  input  logic             rd_start,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [AW-1:0]    rd_addr,
  output logic             rd_last
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    HOLD  = 3'd4,
    READ  = 3'd5
  } state_t;

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  state_t cur, nxt;

  logic [DIVW-1:0]  div_q;
  logic [AW-1:0]    pre_min_q;
  logic [POSTW-1:0] post_len_q;
  logic             edge_q;
  logic [DIVW-1:0]  div_cnt;
  logic [AW-1:0]    pre_cnt;
  logic [POSTW-1:0] post_cnt;
  logic             full;
  logic             prev_match;
  logic [AW:0]      rd_cnt;
  logic             done_nxt;

  logic running, smp, match, fire;
  logic post_end, arm_go, rd_go, rd_acc, rd_fin;

  assign running = (cur == PRE) || (cur == ARMED) || (cur == POST);
  assign smp     = running && (div_cnt == '0);
  assign match   = ((din_sync ^ trig_val) & trig_mask) == 8'h00;
  assign fire    = (cur == ARMED) && smp &&
                   (edge_q ? (match && !prev_match) : match);
  assign post_end = (cur == POST) && smp &&
                    (({1'b0, post_cnt} + (POSTW+1)'(1)) ==
                     {1'b0, post_len_q});
  assign arm_go  = (cur == IDLE) && arm && !abort;
  assign rd_go   = (cur == HOLD) && rd_start && !abort;
  assign rd_acc  = rd_valid && rd_ready;
  assign rd_fin  = rd_acc && (rd_cnt == (AW+1)'(1));

  assign sample_en = smp;
  assign wr_en     = smp;
  assign state     = cur;
  assign rd_valid  = (cur == READ);
  assign rd_last   = rd_valid && (rd_cnt == (AW+1)'(1));

  // Next-state selection; abort overrides everything
  always_comb begin
    nxt      = cur;
    done_nxt = 1'b0;
    if (abort) begin
      nxt = IDLE;
    end else begin
      unique case (cur)
        IDLE:  if (arm) nxt = PRE;
        PRE:   if (pre_cnt >= pre_min_q) nxt = ARMED;
        ARMED: if (fire) nxt = (post_len_q == '0) ? HOLD : POST;
        POST:  if (post_end) nxt = HOLD;
        HOLD:  if (rd_start) nxt = READ;
        READ:  if (rd_fin) nxt = IDLE;
        default: nxt = IDLE;
      endcase
      done_nxt = (nxt == HOLD) && (cur != HOLD);
    end
  end

  // State register and registered done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur  <= IDLE;
      done <= 1'b0;
    end else begin
      cur  <= nxt;
      done <= done_nxt;
    end
  end

  // Config latch, pacing, write pointer, trigger and readout counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= '0;
      pre_min_q  <= '0;
      post_len_q <= '0;
      edge_q     <= 1'b0;
      div_cnt    <= '0;
      pre_cnt    <= '0;
      post_cnt   <= '0;
      full       <= 1'b0;
      prev_match <= 1'b0;
      wptr       <= '0;
      trig_ptr   <= '0;
      rd_addr    <= '0;
      rd_cnt     <= '0;
    end else if (arm_go) begin
      div_q      <= div;
      pre_min_q  <= pre_min;
      post_len_q <= post_len;
      edge_q     <= trig_edge;
      div_cnt    <= '0;
      pre_cnt    <= '0;
      post_cnt   <= '0;
      full       <= 1'b0;
      prev_match <= 1'b0;
      wptr       <= '0;
    end else begin
      if (running) begin
        div_cnt <= (div_cnt == div_q) ? '0 : div_cnt + DIVW'(1);
      end
      if (smp) begin
        wptr       <= wptr + AW'(1);
        prev_match <= match;
        if (wptr == '1) full <= 1'b1;
      end
      if ((cur == PRE) && smp && (pre_cnt != '1)) begin
        pre_cnt <= pre_cnt + AW'(1);
      end
      if (fire && !abort) begin
        trig_ptr <= wptr;
        post_cnt <= '0;
      end
      if ((cur == POST) && smp) begin
        post_cnt <= post_cnt + POSTW'(1);
      end
      if (rd_go) begin
        rd_addr <= full ? wptr : '0;
        rd_cnt  <= full ? DEPTH : {1'b0, wptr};
      end else if (rd_acc) begin
        rd_addr <= rd_addr + AW'(1);
        rd_cnt  <= rd_cnt - (AW+1)'(1);
      end
    end
  end

endmodule
